// File: rtl/reg_arb_defs.sv
// reg_arb_defs: shared definitions for the two-requester register arbiter.
//   state_t   - FSM encodings (2'd3 is unused and decodes to IDLE)
//   REQ0/REQ1 - requester index constants
//   rr_pick   - round-robin selection among pending requests
package reg_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // On a tie the requester that did not write last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_sel);
    if (r0 && r1) return ~last_sel;
    else if (r1)  return REQ1;
    else          return REQ0;
  endfunction

endpackage

// File: rtl/register.sv
// register: plain WIDTH-bit storage element with write enable.
//   clk   - rising-edge clock
//   wr_en - load d_mux at the next edge
//   d_mux - write data
//   z     - stored value
// Holds no reset of its own; the owner clears it by writing zero.
module register #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] d_mux,
  input  logic             clk,
  input  logic             wr_en
);

  always_ff @(posedge clk) begin
    if (wr_en) z <= d_mux;
  end

endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter serializing writes from two four-phase
// requesters into one shared register.
//   clk, rst_n    - clock, synchronous active-low reset
//   req0/d0       - requester 0 request and write data
//   req1/d1       - requester 1 request and write data
//   gnt0/gnt1     - registered grants, never both high
//   z             - shared register contents
//   owner         - requester of the most recent write
//   busy          - FSM not in IDLE
//   wcount        - completed writes, wraps modulo 2^CW
//
// state   | meaning
// IDLE    | waiting for a request, arbitrates pending reqs
// WRITE   | one cycle, register loads d[sel]
// RELEASE | grant held until req[sel] drops
module reg_share_arb
  import reg_arb_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] z,
  output logic             owner,
  output logic             busy,
  output logic [CW-1:0]    wcount
);

  state_t           state;
  logic             sel;
  logic             last;
  logic             nxt_sel;
  logic             wr_en;
  logic [WIDTH-1:0] d_mux;

  assign nxt_sel = rr_pick(req0, req1, last);

  // Reset clears z by forcing a write of zero through the normal port,
  // which also discards any write in flight at that edge.
  assign wr_en = !rst_n || (state == ST_WRITE);
  assign d_mux = !rst_n ? '0 : (sel ? d1 : d0);

  register #(.WIDTH(WIDTH)) u_reg (
    .z     (z),
    .d_mux (d_mux),
    .clk   (clk),
    .wr_en (wr_en)
  );

  assign busy = (state == ST_WRITE) || (state == ST_RELEASE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sel    <= REQ0;
      last   <= REQ1;
      owner  <= REQ0;
      wcount <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
    end else begin
      case (state)
        ST_WRITE: begin
          owner  <= sel;
          last   <= sel;
          wcount <= wcount + 1'b1;
          state  <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!(sel ? req1 : req0)) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          // Covers IDLE and the unused encoding.
          if (req0 || req1) begin
            sel   <= nxt_sel;
            gnt0  <= (nxt_sel == REQ0);
            gnt1  <= (nxt_sel == REQ1);
            state <= ST_WRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arb.sv
module tb_reg_share_arb;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [W-1:0]  d0, d1;
  logic          gnt0, gnt1;
  logic [W-1:0]  z;
  logic          owner;
  logic          busy;
  logic [CW-1:0] wcount;

  reg_share_arb #(.WIDTH(W), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .d0     (d0),
    .req1   (req1),
    .d1     (d1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .z      (z),
    .owner  (owner),
    .busy   (busy),
    .wcount (wcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [W-1:0]  data;
    logic [CW-1:0] wc;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] wc_model = '0;
  int            gcnt0 = 0, gcnt1 = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(input int who, input logic [W-1:0] data);
    exp_t e;
    wc_model = wc_model + 1'b1;
    e.who  = who;
    e.data = data;
    e.wc   = wc_model;
    q.push_back(e);
  endfunction

  // Monitor: a grant rising at negedge k means the write lands at edge k+1.
  initial begin : monitor
    logic pg0, pg1, pend;
    int   pwho;
    exp_t e;
    pg0 = 1'b0; pg1 = 1'b0; pend = 1'b0; pwho = 0;
    forever begin
      @(negedge clk);
      chk("gnt_mutex", {63'd0, gnt0 & gnt1}, 64'd0);
      if (pend) begin
        pend = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("write_who", pwho, e.who);
          chk("write_z", z, e.data);
          chk("write_owner", {63'd0, owner}, e.who);
          chk("write_wcount", wcount, e.wc);
        end
      end
      if (gnt0 && !pg0) begin pend = 1'b1; pwho = 0; gcnt0++; end
      if (gnt1 && !pg1) begin pend = 1'b1; pwho = 1; gcnt1++; end
      pg0 = gnt0;
      pg1 = gnt1;
    end
  end

  task automatic wait_lvl(input int who, input logic lvl);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((who == 1 ? gnt1 : gnt0) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(who == 1 ? "wait_gnt1" : "wait_gnt0", {63'd0, ok}, 64'd1);
  endtask

  // One four-phase transaction: raise, wait grant, drop after the write edge, wait release.
  task automatic do_req(input int who, input logic [W-1:0] data);
    if (who == 1) begin d1 = data; req1 = 1'b1; end
    else          begin d0 = data; req0 = 1'b1; end
    wait_lvl(who, 1'b1);
    @(posedge clk);
    #1;
    if (who == 1) req1 = 1'b0;
    else          req0 = 1'b0;
    wait_lvl(who, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    wc_model = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [CW-1:0] exp_wrap [5];
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset held for two edges with both requests high.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_z", z, 64'd0);
    chk("rst_gnt0", {63'd0, gnt0}, 64'd0);
    chk("rst_gnt1", {63'd0, gnt1}, 64'd0);
    chk("rst_wcount", wcount, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Single requester with explicit latency checks.
    d0 = 32'hDEADBEEF; req0 = 1'b1;
    push_exp(0, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    chk("single_gnt0", {63'd0, gnt0}, 64'd1);
    chk("single_gnt1", {63'd0, gnt1}, 64'd0);
    chk("single_z_not_yet", z, 64'd0);
    chk("single_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("single_z", z, 64'hDEADBEEF);
    chk("single_wcount", wcount, 64'd1);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("single_gnt0_fall", {63'd0, gnt0}, 64'd0);
    chk("single_busy_fall", {63'd0, busy}, 64'd0);

    // Tie right after reset: requester 0 first, then 1.
    reset_pulse();
    push_exp(0, 32'd5);
    push_exp(1, 32'd9);
    fork
      do_req(0, 32'd5);
      do_req(1, 32'd9);
    join
    chk("tie_z", z, 64'd9);
    chk("tie_owner", {63'd0, owner}, 64'd1);
    chk("tie_wcount", wcount, 64'd2);

    // Fairness: last writer was 1, so 0 leads and grants alternate.
    gcnt0 = 0; gcnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      push_exp(0, 32'hA000_0000 + i);
      push_exp(1, 32'hB000_0000 + i);
    end
    fork
      for (int i = 0; i < 5; i++) do_req(0, 32'hA000_0000 + i);
      for (int j = 0; j < 5; j++) do_req(1, 32'hB000_0000 + j);
    join
    chk("fair_cnt0", gcnt0, 64'd5);
    chk("fair_cnt1", gcnt1, 64'd5);

    // Reset while requester 1 holds its grant in RELEASE.
    d1 = 32'h0000_1234; req1 = 1'b1;
    push_exp(1, 32'h0000_1234);
    wait_lvl(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("midrel_gnt1_held", {63'd0, gnt1}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrel_gnt1", {63'd0, gnt1}, 64'd0);
    chk("midrel_z", z, 64'd0);
    chk("midrel_busy", {63'd0, busy}, 64'd0);
    chk("midrel_wcount", wcount, 64'd0);
    wc_model = '0;
    push_exp(1, 32'h0000_1234);
    rst_n = 1'b1;
    wait_lvl(1, 1'b1);
    @(posedge clk);
    #1;
    req1 = 1'b0;
    wait_lvl(1, 1'b0);

    // Counter wrap with a 2-bit counter.
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      push_exp(0, 32'd100 + i);
      do_req(0, 32'd100 + i);
      chk("wrap_wcount", wcount, exp_wrap[i]);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
